dff_share_arb: RTL
==================

DFF_SHARE_ARB -- requirements
Module: dff_share_arb

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning the number of requesters sharing the register (N >= 2).
REQ-002 The module SHALL have parameter W, default 8, meaning the width of the shared register and of each write-data slice.
REQ-003 The module SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port req  input  N  per-requester write request, held high until ack or withdrawn.
REQ-006 The module SHALL have port wdata  input  N*W  write data, with requester i using bits [i*W +: W].
REQ-007 The module SHALL have port gnt  output  N  registered one-hot grant.
REQ-008 The module SHALL have port ack  output  N  registered one-hot write-done pulse, one cycle wide.
REQ-009 The module SHALL have port q  output  W  shared register contents.
REQ-010 The module SHALL have port wr_cnt  output  8  count of committed writes, wrapping.
REQ-011 The module SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and COMMIT.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with gnt, ack and q unchanged.
REQ-014 In IDLE with req != 0, the winner SHALL be the first requester with req set, searching ptr, ptr+1, ... mod N; the block SHALL register win, set gnt = onehot(win) and enter GRANT.
REQ-015 In GRANT with req[win] still 1, the block SHALL load q with wdata slice win, set ack = onehot(win), clear gnt, increment wr_cnt and enter COMMIT.
REQ-016 In GRANT with req[win] == 0 (withdrawn), the block SHALL abort: clear gnt, leave q, ack and wr_cnt unchanged, set ptr = (win+1) mod N and return to IDLE.
REQ-017 In COMMIT, the block SHALL clear ack, set ptr = (win+1) mod N and return to IDLE unconditionally.
REQ-018 Latency: with req sampled at edge k in IDLE, gnt SHALL be high in cycle k+1, q and ack SHALL update at edge k+2, and the block SHALL be back in IDLE at edge k+3.
REQ-019 Peak throughput SHALL be one write per 3 cycles.
REQ-020 No requester SHALL wait more than N transactions while continuously requesting.
REQ-021 gnt and ack SHALL each be zero or one-hot at all times, and SHALL never be nonzero in the same cycle.
REQ-022 Only the granted requester's wdata slice SHALL ever reach q; wdata SHALL be sampled only at the GRANT edge.
REQ-023 Requests from non-winners that arrive or drop during GRANT or COMMIT SHALL be ignored until the next IDLE.
REQ-024 ptr SHALL wrap from N-1 to 0, and wr_cnt SHALL wrap from 255 to 0.
REQ-025 busy SHALL equal (state != IDLE), decoded from registered state.

Reset
REQ-026 When rst is 1 at posedge clk, the block SHALL set state = IDLE, ptr = 0, win = 0, gnt = 0, ack = 0, q = 0, wr_cnt = 0 and busy = 0, overriding every other input.
REQ-027 If rst is asserted during GRANT or COMMIT, the transaction SHALL be dropped with no q update, and no ack SHALL appear after reset.
REQ-028 Requests present in the first cycle after rst deasserts SHALL be arbitrated normally starting from ptr = 0.

Verification
REQ-029 Single requester: N=4, W=8, req=0001 and wdata[7:0]=8'hA5 held -> gnt=0001 in cycle 1, q=8'hA5 and ack=0001 in cycle 2, wr_cnt=1, busy low in cycle 3.
REQ-030 Round-robin: req=1111 held for 12 cycles -> grant order 0,1,2,3, four acks, wr_cnt=4, no gnt/ack overlap.
REQ-031 Withdraw: req=0100 for one cycle, then 0 -> gnt=0100 for one cycle, no ack, q unchanged, wr_cnt unchanged, next request from 3 wins over 2 when both are set.
REQ-032 Mid-operation reset: rst pulsed in the COMMIT cycle of a write of 8'h3C -> all outputs 0 next cycle, no later ack.
REQ-033 Wrap: 256 back-to-back writes from requester 1 -> wr_cnt returns to 0, q equals the last data, and ptr wraps correctly when requester 3 is followed by requester 0.
REQ-034 Starvation check: req=1011 held with random wdata -> requester 3 is granted within 4 transactions and q always matches the granted slice.

Source files
------------

// File: rtl/dff_share_arb.sv
// Shared W-bit register written by N requesters through a round-robin arbiter.
// Each write runs IDLE -> GRANT -> COMMIT, so one write completes every three cycles at most.
module dff_share_arb #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   wdata,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
    output logic [W-1:0]     q,
    output logic [7:0]       wr_cnt,
    output logic             busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        COMMIT
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_n;
    logic [PW-1:0] win;
    logic [PW-1:0] win_n;
    logic [PW-1:0] win_inc;
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    logic          found;
    logic [N-1:0]  gnt_n;
    logic [N-1:0]  ack_n;
    logic [W-1:0]  q_n;
    logic [W-1:0]  slice;
    logic [7:0]    cnt_n;

    // Round-robin search: first set request starting at ptr and wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        slice = '0;
        for (int i = 0; i < N; i++) begin
            if (win == PW'(i)) begin
                slice = wdata[i*W +: W];
            end
        end
    end

    assign win_inc = (win == PW'(N - 1)) ? '0 : win + PW'(1);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        win_n   = win;
        gnt_n   = gnt;
        ack_n   = ack;
        q_n     = q;
        cnt_n   = wr_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    win_n       = pick;
                    gnt_n       = '0;
                    gnt_n[pick] = 1'b1;
                    state_n     = GRANT;
                end
            end
            GRANT: begin
                gnt_n = '0;
                // A withdrawn request aborts without touching q, ack or the write count.
                if (req[win]) begin
                    q_n        = slice;
                    ack_n      = '0;
                    ack_n[win] = 1'b1;
                    cnt_n      = wr_cnt + 8'd1;
                    state_n    = COMMIT;
                end else begin
                    ptr_n   = win_inc;
                    state_n = IDLE;
                end
            end
            COMMIT: begin
                ack_n   = '0;
                ptr_n   = win_inc;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            win    <= '0;
            gnt    <= '0;
            ack    <= '0;
            q      <= '0;
            wr_cnt <= '0;
        end else begin
            ptr    <= ptr_n;
            win    <= win_n;
            gnt    <= gnt_n;
            ack    <= ack_n;
            q      <= q_n;
            wr_cnt <= cnt_n;
        end
    end

    assign busy = (state != IDLE);

endmodule
